// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the chunked multi-cycle adder: controller state codes
// and parameter-derived widths.
package multiword_add_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int unsigned mw_width(input int unsigned chunk, input int unsigned nchunk);
    return chunk * nchunk;
  endfunction

  // Chunk index needs at least one bit even when there is only one chunk.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multiword_add_seq_ripplecarrryadder.sv
// N-bit ripple-carry adder exposing the carry out of every bit position;
// Cout[SIZE-1] is the word carry, Cout[SIZE-2] the carry into the MSB.
module ripplecarrryadder #(
  parameter int unsigned SIZE = 4
) (
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  input  logic            Cin,
  output logic [SIZE-1:0] S,
  output logic [SIZE-1:0] Cout
);

  logic w_c;

  always_comb begin
    S    = '0;
    Cout = '0;
    w_c  = Cin;
    for (int unsigned i = 0; i < SIZE; i++) begin
      S[i]    = A[i] ^ B[i] ^ w_c;
      Cout[i] = (A[i] & B[i]) | (w_c & (A[i] ^ B[i]));
      w_c     = Cout[i];
    end
  end

endmodule

// File: rtl/multiword_add_seq.sv
// WIDTH-bit add/subtract sequenced over NCHUNK cycles through one shared
// CHUNK-bit ripple-carry adder, LSB chunk first, carry registered between chunks.
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter  int unsigned CHUNK  = 4,
  parameter  int unsigned NCHUNK = 4,
  localparam int unsigned WIDTH  = mw_width(CHUNK, NCHUNK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned IW = idx_width(NCHUNK);

  logic [1:0]       r_state;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_s;
  logic [CHUNK-1:0] w_cvec;
  logic             w_last;

  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (r_idx == IW'(i)) begin
        w_a_chunk = r_a[i*CHUNK +: CHUNK];
        w_b_chunk = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  assign w_last = (r_idx == IW'(NCHUNK - 1));

  ripplecarrryadder #(.SIZE(CHUNK)) u_adder (
    .A    (w_a_chunk),
    .B    (w_b_chunk),
    .Cin  (r_carry),
    .S    (w_s),
    .Cout (w_cvec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (r_idx == IW'(i)) r_sum[i*CHUNK +: CHUNK] <= w_s;
          end
          r_carry <= w_cvec[CHUNK-1];
          // idx wraps to 0 on the final chunk so it never exceeds NCHUNK-1.
          if (w_last) begin
            r_idx   <= '0;
            r_cout  <= w_cvec[CHUNK-1];
            r_ovf   <= w_cvec[CHUNK-1] ^ w_cvec[CHUNK-2];
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = rst_n && (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Randomized self-checking bench for multiword_add_seq against an arithmetic
// reference (plain WIDTH+1-bit addition) at CHUNK=4, NCHUNK=4.
module tb_multiword_add_seq;

  localparam int unsigned CHUNK  = 4;
  localparam int unsigned NCHUNK = 4;
  localparam int unsigned WIDTH  = CHUNK * NCHUNK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  multiword_add_seq #(.CHUNK(CHUNK), .NCHUNK(NCHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain WIDTH+1 bit arithmetic; ovf from operand/result signs.
  task automatic ref_model(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                           input logic rcin, input logic rsub,
                           output logic [WIDTH-1:0] es, output logic ec, output logic eo);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] bb;
    bb   = rsub ? (~rb) : rb;
    full = {1'b0, ra} + {1'b0, bb} + (WIDTH+1)'(rsub ? 1'b1 : rcin);
    es   = full[WIDTH-1:0];
    ec   = full[WIDTH];
    eo   = (ra[WIDTH-1] == bb[WIDTH-1]) && (es[WIDTH-1] != ra[WIDTH-1]);
  endtask

  // Issue one operation, scramble inputs during RUN, hold the sink off for
  // `hold` cycles while offering a competing request, then complete it.
  task automatic run_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                        input logic ocin, input logic osub, input int unsigned hold);
    logic [WIDTH-1:0] es;
    logic             ec, eo;
    int unsigned      cnt;
    ref_model(oa, ob, ocin, osub, es, ec, eo);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = oa; b = ob; cin = ocin; sub = osub;
    tick();
    in_valid = 1'b0;
    chk("busy_run", 32'(busy), 32'd1);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'($urandom);
      tick();
      cnt++;
    end
    in_valid = 1'b0;
    chk("latency", cnt, NCHUNK);
    chk("sum", 32'(sum), 32'(es));
    chk("cout", 32'(cout), 32'(ec));
    chk("ovf", 32'(ovf), 32'(eo));
    for (int unsigned h = 0; h < hold; h++) begin
      out_ready = 1'b0; in_valid = 1'b1; a = 16'h1111; b = 16'h1111;
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_sum", 32'(sum), 32'(es));
      chk("bp_cout_ovf", {30'd0, cout, ovf}, {30'd0, ec, eo});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drop_valid", 32'(out_valid), 32'd0);
    chk("ready_after", 32'(in_ready), 32'd1);
    chk("held_sum", 32'(sum), 32'(es));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", {15'd0, cout, ovf, sum}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_release", 32'(in_ready), 32'd1);

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    chk("tp_5555", 32'(sum), 32'h5555);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    chk("tp_wrap", {15'd0, cout, ovf, sum}, {15'd0, 1'b1, 1'b0, 16'h0000});
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
    chk("tp_cin", {15'd0, cout, ovf, sum}, {15'd0, 1'b1, 1'b0, 16'h0000});
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    chk("tp_ovf", {15'd0, cout, ovf, sum}, {15'd0, 1'b0, 1'b1, 16'h8000});
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 3);
    chk("tp_sub", {15'd0, cout, ovf, sum}, {15'd0, 1'b0, 1'b0, 16'hFFFE});

    // Abort during the second RUN cycle.
    in_valid = 1'b1; a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_regs", {15'd0, cout, ovf, sum}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("abort_ready", 32'(in_ready), 32'd1);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);
    chk("after_abort", 32'(sum), 32'h0002);

    for (int k = 0; k < 40; k++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
